// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared types and constants for the Ethernet transmit arbiter.
//               - eth_tx_arb_state_t : arbiter state encoding
//               - FRAME_CNT_W        : width of the completed-frame counter
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

  // ABORT and DRAIN are only reachable when the stall watchdog is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } eth_tx_arb_state_t;

  localparam int FRAME_CNT_W = 16;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/eth_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : eth_rr_select
// Description : Purely combinational round-robin selector. Searches req
//               starting at ptr+1 and wrapping modulo N_SRC; the first
//               asserted request wins.
// Ports       : req     [N_SRC-1:0] request vector
//               ptr     [IDX_W-1:0] index of the most recently served source
//               win     [N_SRC-1:0] one-hot winner (0 when no request)
//               win_idx [IDX_W-1:0] binary index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rr_select
  import eth_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  int   cand;
  logic found;

  // k runs 1..N_SRC so the previous owner is considered last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = (int'(ptr) + k) % N_SRC;
      if (!found && req[cand]) begin
        found      = 1'b1;
        win[cand]  = 1'b1;
        win_idx    = cand[IDX_W-1:0];
      end
    end
  end

endmodule : eth_rr_select
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Frame-granular round-robin arbiter sharing one UDP transmit
//               payload stream between N_SRC byte-stream sources. A granted
//               source owns the output until its tlast handshake; frames are
//               never interleaved. One IDLE cycle is spent per arbitration.
// Config      : ETH_TX_ARB_TIMEOUT_EN - compiles in the mid-frame stall
//               watchdog (ABORT/DRAIN states, TIMEOUT_CYCLES limit).
// Ports       : clk, reset (async, active-low)
//               s_tdata/s_tvalid/s_tready/s_tlast/s_tuser : source streams
//               m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : output stream
//               grant       one-hot current owner, 0 when idle
//               busy        high in any state other than IDLE
//               frame_count completed output frames (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N_SRC          = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] s_tdata,
  input  logic [N_SRC-1:0]        s_tvalid,
  output logic [N_SRC-1:0]        s_tready,
  input  logic [N_SRC-1:0]        s_tlast,
  input  logic [N_SRC-1:0]        s_tuser,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic [N_SRC-1:0]        grant,
  output logic                    busy,
  output logic [FRAME_CNT_W-1:0]  frame_count
);

  localparam int IDX_W = $clog2(N_SRC);

  eth_tx_arb_state_t state, state_nxt;

  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [N_SRC-1:0] rr_win;
  logic [IDX_W-1:0] rr_win_idx;

  logic start_arb;
  logic pass_done;
  logic frame_end;
  logic count_frame;

  eth_rr_select #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req     (s_tvalid),
    .ptr     (ptr),
    .win     (rr_win),
    .win_idx (rr_win_idx)
  );

  assign start_arb = (state == IDLE) && (|s_tvalid);
  assign pass_done = (state == PASS) && s_tvalid[owner] && m_tready && s_tlast[owner];

`ifdef ETH_TX_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_hit;
  logic               abort_done;
  logic               drain_done;

  // Gated by the current valid so a source resuming on the very cycle the
  // limit is reached still gets its beat through instead of being aborted.
  assign stall_hit  = (state == PASS) && (stall_cnt == STALL_LIMIT) && !s_tvalid[owner];
  assign abort_done = (state == ABORT) && m_tready;
  assign drain_done = (state == DRAIN) && s_tvalid[owner] && s_tlast[owner];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if ((state == PASS) && !s_tvalid[owner]) begin
      if (stall_cnt != STALL_LIMIT) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

  assign frame_end   = pass_done | drain_done;
  assign count_frame = pass_done | abort_done;
`else
  assign frame_end   = pass_done;
  assign count_frame = pass_done;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_arb) state_nxt = PASS;
      end
      PASS: begin
        if (pass_done) begin
          state_nxt = IDLE;
        end
`ifdef ETH_TX_ARB_TIMEOUT_EN
        else if (stall_hit) begin
          state_nxt = ABORT;
        end
`endif
      end
`ifdef ETH_TX_ARB_TIMEOUT_EN
      ABORT: begin
        if (abort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership, rotating pointer and frame counter. ptr records the owner on
  // the final handshake so the next search starts just after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      owner       <= '0;
      ptr         <= IDX_W'(N_SRC - 1);
      frame_count <= '0;
    end else begin
      if (start_arb) begin
        grant <= rr_win;
        owner <= rr_win_idx;
      end
      if (frame_end) begin
        grant <= '0;
        ptr   <= owner;
      end
      if (count_frame) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  // Output logic: zero-latency mux from the owner while passing.
  always_comb begin
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    case (state)
      PASS: begin
        m_tdata         = s_tdata[owner*DATA_W +: DATA_W];
        m_tvalid        = s_tvalid[owner];
        m_tlast         = s_tlast[owner];
        m_tuser         = s_tuser[owner];
        s_tready[owner] = m_tready;
      end
`ifdef ETH_TX_ARB_TIMEOUT_EN
      // Synthetic terminating beat flagged as errored.
      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
      end
      // Swallow the rest of the stalled frame without forwarding it.
      DRAIN: begin
        s_tready[owner] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule : eth_tx_arbiter
`default_nettype wire
